// File: rtl/mel_filter_stream.sv
// Mel filter bank engine: takes one frame of N unsigned spectral bins and
// walks the bins one per cycle. Each bin is weighted by externally supplied
// triangular-filter coefficients, and NF filter energies are accumulated.
// The results are right-shifted, saturated to OW bits and presented on a
// held output handshake. Each bin may feed two adjacent filters: the
// rising slope of filter f and the falling slope of filter f-1.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | s_ready=1, waiting for a frame
//   ST_ACCUM | one bin per cycle through the coefficient ROM
//   ST_OUT   | m_valid=1, energies held until m_ready
module mel_filter_stream #(
   parameter int N     = 256,
   parameter int DW    = 16,
   parameter int NF    = 40,
   parameter int WW    = 8,
   parameter int OW    = 16,
   parameter int SHIFT = 8,
   localparam int IW   = $clog2(N),
   localparam int FW   = $clog2(NF + 1),
   localparam int AW   = DW + WW + 1 + IW
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            s_valid,
   output logic            s_ready,
   input  logic [N*DW-1:0] in,
   output logic            m_valid,
   input  logic            m_ready,
   output logic [NF*OW-1:0] out,
   output logic [IW-1:0]   coef_idx,
   input  logic [FW-1:0]   coef_filt,
   input  logic [WW-1:0]   coef_w
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_OUT   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [DW-1:0]     buf_q [N];
   logic [DW-1:0]     buf_d [N];
   logic [AW-1:0]     acc_q [NF];
   logic [AW-1:0]     acc_d [NF];
   logic [OW-1:0]     out_q [NF];
   logic [OW-1:0]     out_d [NF];

   logic [DW-1:0]     bin_x;
   logic [WW:0]       w_fall;
   logic [DW+WW-1:0]  prod_rise;
   logic [DW+WW:0]    prod_fall;
   logic              last_bin;

   // Shift then clamp. AW is always wider than OW for sane parameters, so the
   // bits above OW tell us whether the shifted value overflows the output.
   function automatic logic [OW-1:0] sat_energy(input logic [AW-1:0] a);
      logic [AW-1:0] s;
      s = a >> SHIFT;
      if (|s[AW-1:OW]) begin
         return '1;
      end
      return s[OW-1:0];
   endfunction

   // Handshake flags come straight from the state register.
   always_comb begin
      s_ready  = (state_q == ST_IDLE);
      m_valid  = (state_q == ST_OUT);
      coef_idx = idx_q;
   end

   // Current bin and its rising/falling slope products. The falling weight
   // is 2^WW - w and needs one extra bit so that w=0 gives full weight.
   always_comb begin
      bin_x     = buf_q[idx_q];
      w_fall    = {1'b1, {WW{1'b0}}} - {1'b0, coef_w};
      prod_rise = {{WW{1'b0}}, bin_x} * {{DW{1'b0}}, coef_w};
      prod_fall = {{(WW+1){1'b0}}, bin_x} * {{DW{1'b0}}, w_fall};
      last_bin  = (idx_q == IW'(N - 1));
   end

   // Next-state, frame buffer load, accumulation and output capture.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      buf_d   = buf_q;
      acc_d   = acc_q;
      out_d   = out_q;
      case (state_q)
         ST_IDLE: begin
            if (s_valid) begin
               for (int k = 0; k < N; k++) begin
                  buf_d[k] = in[k*DW +: DW];
               end
               for (int i = 0; i < NF; i++) begin
                  acc_d[i] = '0;
               end
               idx_d   = '0;
               state_d = ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            // Filter f takes the rising product, filter f-1 the falling one.
            // Out-of-range f matches no filter and so contributes nothing.
            for (int i = 0; i < NF; i++) begin
               if (coef_filt == FW'(i)) begin
                  acc_d[i] = acc_d[i] + AW'(prod_rise);
               end
               if (coef_filt == FW'(i + 1)) begin
                  acc_d[i] = acc_d[i] + AW'(prod_fall);
               end
            end
            if (last_bin) begin
               idx_d   = '0;
               state_d = ST_OUT;
               // Capture uses acc_d so the final bin is included.
               for (int i = 0; i < NF; i++) begin
                  out_d[i] = sat_energy(acc_d[i]);
               end
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         ST_OUT: begin
            if (m_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any frame in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         for (int k = 0; k < N; k++) begin
            buf_q[k] <= '0;
         end
         for (int i = 0; i < NF; i++) begin
            acc_q[i] <= '0;
            out_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         buf_q   <= buf_d;
         acc_q   <= acc_d;
         out_q   <= out_d;
      end
   end

   // Flatten the held energies onto the output bus.
   always_comb begin
      out = '0;
      for (int i = 0; i < NF; i++) begin
         out[i*OW +: OW] = out_q[i];
      end
   end

endmodule

// File: tb/tb_mel_filter_stream.sv
// Self-checking bench for mel_filter_stream at default parameters. A
// combinational ROM model answers coef_idx. Expected energy vectors are
// queued at frame accept and popped at the output handshake.
module tb_mel_filter_stream;

   localparam int N  = 256;
   localparam int DW = 16;
   localparam int NF = 40;
   localparam int WW = 8;
   localparam int OW = 16;
   localparam int IW = 8;
   localparam int FW = 6;

   typedef logic [NF*OW-1:0] outv_t;
   typedef logic [N*DW-1:0]  frame_t;

   typedef struct {
      string name;
      int    bin;
      int    val;
      int    f;
      int    w;
      int    i0;
      int    e0;
      int    i1;
      int    e1;
   } vec_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          s_valid;
   logic          s_ready;
   frame_t        in_v;
   logic          m_valid;
   logic          m_ready;
   outv_t         out_v;
   logic [IW-1:0] coef_idx;
   logic [FW-1:0] coef_filt;
   logic [WW-1:0] coef_w;

   logic [FW-1:0] rom_f [N];
   logic [WW-1:0] rom_w [N];

   outv_t exp_q [$];
   int    n_checks = 0;
   int    n_pass   = 0;

   mel_filter_stream dut (
      .clk       (clk),
      .reset     (reset),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .in        (in_v),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .out       (out_v),
      .coef_idx  (coef_idx),
      .coef_filt (coef_filt),
      .coef_w    (coef_w)
   );

   always #5 clk = ~clk;

   assign coef_filt = rom_f[coef_idx];
   assign coef_w    = rom_w[coef_idx];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h required %0h", name, act, req);
   endtask

   task automatic check_out(input string name, input outv_t req);
      n_checks++;
      if (out_v === req) begin
         n_pass++;
      end else begin
         for (int i = 0; i < NF; i++) begin
            if (out_v[i*OW +: OW] !== req[i*OW +: OW]) begin
               $display("FAIL %s: out[%0d] got %0h required %0h", name, i,
                        out_v[i*OW +: OW], req[i*OW +: OW]);
               break;
            end
         end
      end
   endtask

   task automatic rom_default();
      for (int k = 0; k < N; k++) begin
         rom_f[k] = FW'(NF + 1);
         rom_w[k] = 8'd77;
      end
   endtask

   // Reference: straightforward per-bin sum over the ROM contents.
   function automatic outv_t ref_model(input frame_t fr);
      longint unsigned acc [NF];
      longint unsigned x, s;
      int f, w;
      outv_t e;
      for (int i = 0; i < NF; i++) acc[i] = 0;
      for (int k = 0; k < N; k++) begin
         x = longint'(fr[k*DW +: DW]);
         f = int'(rom_f[k]);
         w = int'(rom_w[k]);
         if (f < NF) acc[f] += x * longint'(w);
         if (f >= 1 && f <= NF) acc[f-1] += x * longint'(256 - w);
      end
      e = '0;
      for (int i = 0; i < NF; i++) begin
         s = acc[i] >> 8;
         if (s > 64'd65535) s = 64'd65535;
         e[i*OW +: OW] = s[15:0];
      end
      return e;
   endfunction

   // Drive a frame at a negedge, queue its expectation, and let it be accepted.
   task automatic send(input string name, input frame_t fr, input outv_t ev);
      int n = 0;
      while (!s_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({name, "_s_ready"}, s_ready, 1);
      s_valid = 1'b1;
      in_v    = fr;
      exp_q.push_back(ev);
      @(posedge clk);
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   // Count edges after accept until m_valid; must be exactly N.
   task automatic wait_valid(input string name);
      int cyc = 0;
      while (!m_valid && cyc < 2*N) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
      end
      check({name, "_latency"}, cyc, N);
   endtask

   // Output handshake: pop and compare, then the block must be idle again.
   task automatic drain(input string name);
      outv_t ev;
      m_ready = 1'b1;
      n_checks++;
      if (exp_q.size() == 0) begin
         $display("FAIL %s_sb: output with no queued expectation", name);
      end else begin
         n_pass++;
         ev = exp_q.pop_front();
         check_out({name, "_out"}, ev);
      end
      @(posedge clk);
      @(negedge clk);
      m_ready = 1'b0;
      check({name, "_post_hs"}, {m_valid, s_ready}, 2'b01);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t   vecs [7];
      frame_t fr, fr_b;
      outv_t  ev, ev_b, snap;
      logic   ok;
      int     n;

      vecs[0] = '{"impulse",   10,   100,  3,  64,  3,   25,  2,  75};
      vecs[1] = '{"edge_f0",    5,   200,  0, 128,  0,  100, -1,   0};
      vecs[2] = '{"edge_fNF",   5,   200, 40,   0, 39,  200, -1,   0};
      vecs[3] = '{"last_bin", 255, 65535, 20, 255, 20, 65279, 19, 255};
      vecs[4] = '{"first_bin",  0,  1000, 39, 200, 39,  781, 38, 218};
      vecs[5] = '{"f_beyond",   7,   500, 45,  10, -1,    0, -1,   0};
      vecs[6] = '{"f1_w0",      3,   300,  1,   0,  0,  300, -1,   0};

      reset = 1'b1; s_valid = 1'b0; m_ready = 1'b0; in_v = '0;
      rom_default();
      repeat (3) @(negedge clk);
      check("rst_s_ready",  s_ready,  1);
      check("rst_m_valid",  m_valid,  0);
      check("rst_coef_idx", coef_idx, 0);
      check("rst_out_zero", (out_v == '0), 1);
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_state", {s_ready, m_valid}, 2'b10);

      for (int t = 0; t < 7; t++) begin
         rom_default();
         rom_f[vecs[t].bin] = FW'(vecs[t].f);
         rom_w[vecs[t].bin] = WW'(vecs[t].w);
         fr = '0;
         fr[vecs[t].bin*DW +: DW] = DW'(vecs[t].val);
         ev = '0;
         if (vecs[t].i0 >= 0) ev[vecs[t].i0*OW +: OW] = OW'(vecs[t].e0);
         if (vecs[t].i1 >= 0) ev[vecs[t].i1*OW +: OW] = OW'(vecs[t].e1);
         send(vecs[t].name, fr, ev);
         wait_valid(vecs[t].name);
         drain(vecs[t].name);
      end

      // Saturation: every bin full-scale into filter 0 with w=255.
      for (int k = 0; k < N; k++) begin
         rom_f[k] = '0;
         rom_w[k] = 8'd255;
      end
      fr = '1;
      ev = '0;
      ev[OW-1:0] = 16'hFFFF;
      send("saturate", fr, ev);
      wait_valid("saturate");
      drain("saturate");

      // Random frame and ROM checked against the reference sum.
      for (int k = 0; k < N; k++) begin
         rom_f[k] = FW'($urandom_range(0, NF + 3));
         rom_w[k] = WW'($urandom_range(0, 255));
         fr[k*DW +: DW] = DW'($urandom_range(0, 4095));
      end
      ev = ref_model(fr);
      send("random", fr, ev);
      wait_valid("random");
      drain("random");

      // Backpressure: output held while a second frame waits upstream.
      for (int k = 0; k < N; k++) fr_b[k*DW +: DW] = DW'($urandom_range(0, 4095));
      ev_b = ref_model(fr_b);
      send("bp_a", fr, ev);
      wait_valid("bp_a");
      s_valid = 1'b1;
      in_v    = fr_b;
      snap    = out_v;
      ok      = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (out_v !== snap || s_ready !== 1'b0 || m_valid !== 1'b1) ok = 1'b0;
      end
      check("bp_hold", ok, 1);
      drain("bp_a");
      exp_q.push_back(ev_b);
      @(posedge clk);
      @(negedge clk);
      s_valid = 1'b0;
      wait_valid("bp_b");
      drain("bp_b");

      // Reset while holding output: must clear immediately, no handshake.
      rom_default();
      rom_f[10] = 6'd3;
      rom_w[10] = 8'd64;
      fr = '0;
      fr[10*DW +: DW] = 16'd100;
      ev = '0;
      ev[3*OW +: OW] = 16'd25;
      ev[2*OW +: OW] = 16'd75;
      send("rst_out", fr, ev);
      wait_valid("rst_out");
      reset = 1'b1;
      #1;
      check("rst_out_clear", {s_ready, m_valid, coef_idx, (out_v == '0)}, {2'b10, 8'd0, 1'b1});
      void'(exp_q.pop_back());
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Reset mid-accumulation at coef_idx==100 using a different frame.
      // Out first holds a prior result so clearing it is observable.
      send("pre_abort", fr, ev);
      wait_valid("pre_abort");
      drain("pre_abort");
      fr_b = '0;
      fr_b[10*DW +: DW] = 16'd5000;
      fr_b[20*DW +: DW] = 16'd777;
      send("abort", fr_b, '0);
      n = 0;
      while (coef_idx != 8'd100 && n < 2*N) begin
         @(negedge clk);
         n++;
      end
      check("abort_reached_100", coef_idx, 100);
      reset = 1'b1;
      #1;
      check("abort_clear", {s_ready, m_valid, coef_idx, (out_v == '0)}, {2'b10, 8'd0, 1'b1});
      exp_q.delete();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      ok = 1'b1;
      for (int c = 0; c < N + 10; c++) begin
         @(negedge clk);
         if (m_valid !== 1'b0) ok = 1'b0;
      end
      check("abort_no_valid", ok, 1);
      send("after_abort", fr, ev);
      wait_valid("after_abort");
      drain("after_abort");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mel_filter_stream.md
# mel_filter_stream

Parametrised mel filter bank engine for the audio-processing chain, placed between the power-spectrum stage and the cepstral/feature stage. It accepts one frame of N spectral bins per valid/ready handshake and buffers it internally. It then streams the bins one per cycle through externally supplied triangular-filter coefficients and accumulates NF filter energies. It presents the saturated, scaled energies on a held output handshake. Unlike the previous fixed wrapper, data, weight and output widths, filter count and scaling are parameters, and every bin may contribute to two overlapping filters.

## Interface
- N, 256: bins per frame (≥2)
- DW, 16: input bin width (unsigned)
- NF, 40: number of mel filters (≥2)
- WW, 8: coefficient weight width (unsigned)
- OW, 16: output energy width
- SHIFT, 8: right shift applied to accumulators before saturation
- Derived: IW = $clog2(N), FW = $clog2(NF+1), AW = DW+WW+1+IW (accumulator width)
- Reset `reset` is asynchronous and active-high. The clock is `clk`.
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- s_valid  in  1  input frame valid
- s_ready  out  1  block can accept a frame
- in  in  DW×N  spectral bins, sampled only on accept
- m_valid  out  1  output frame valid
- m_ready  in  1  downstream accepts output
- out  out  OW×NF  filter energies
- coef_idx  out  IW  bin index currently being processed (drives external coefficient ROM)
- coef_filt  in  FW  rising-slope filter index for bin coef_idx, same cycle (combinational)
- coef_w  in  WW  rising-slope weight for bin coef_idx, same cycle

## Operation
- FSM states:
  - IDLE: s_ready=1.
  - ACCUM: processes bins.
  - OUT: m_valid=1.
- IDLE: on s_valid&&s_ready, copy all N bins into the frame buffer, clear all NF accumulators, set coef_idx=0, go to ACCUM.
- ACCUM: each cycle, with x = buf[coef_idx], f = coef_filt, w = coef_w:
  - if f<NF: acc[f] += x·w
  - if 1≤f≤NF: acc[f-1] += x·(2^WW − w), where the falling weight is WW+1 bits
  - if f>NF: no contribution
  - both updates occur in the same cycle; they never collide because f ≠ f−1
- coef_idx increments each ACCUM cycle. On the cycle with coef_idx==N−1, the bin is processed, coef_idx wraps to 0, and the state goes to OUT.
- Entering OUT registers out[i] = min(acc[i] >> SHIFT, 2^OW−1) for all i, and raises m_valid.
- OUT: out and m_valid are held stable until m_valid&&m_ready, then the state returns to IDLE.
- No frame overlap: s_ready=0 in ACCUM and OUT. s_valid is ignored in those states, and upstream must hold its frame.
- Arithmetic is unsigned throughout. Accumulators cannot overflow with AW as defined.

## Timing
- Reset values:
  - state IDLE, so s_ready=1 during and after reset
  - m_valid=0, all out=0, coef_idx=0
  - accumulators and buffer 0
- Reset asserted mid-ACCUM or mid-OUT aborts the frame immediately. No partial output is ever presented.
- Accept on edge T. Bin k is processed on edge T+1+k. m_valid rises after edge T+N, so it is visible in cycle T+N+1. Accept-to-valid latency is N+1 cycles.
- Back-to-back throughput: one frame per N+2 cycles when m_ready is tied high. Cycles are: accept, N processing cycles, one OUT cycle. s_ready rises the cycle after the output handshake.
- s_ready and m_valid are decoded directly from state registers, with no combinational path from s_valid or m_ready.
- coef_filt/coef_w must be valid in the same cycle that coef_idx is driven. This requires an asynchronous-read ROM or a ROM whose registered address has been pre-advanced externally.

## Test plan
- Reset: assert reset at arbitrary times.
  - Required: s_ready=1, m_valid=0, all out=0, coef_idx=0 within the same cycle.
- Single impulse (default params): in[10]=100, all other bins 0; ROM maps bin 10 → f=3, w=64, and all other bins → f=NF+1.
  - Required: out[3]=25, out[2]=75, all others 0; m_valid first high in cycle T+257.
- Edge filters:
  - bin 5=200 with f=0, w=128 → out[0]=100 only.
  - bin 5=200 with f=NF(40), w=0 → out[39]=200 only.
- Saturation: all bins 0xFFFF, every bin mapped to f=0, w=255.
  - Required: out[0]=0xFFFF (clamped), out[1..39]=0.
- Backpressure: hold m_ready low for 20 cycles after m_valid rises while s_valid stays high with a different frame.
  - Required: out stable, s_ready=0, no accept.
  - After m_ready=1 for one cycle: m_valid=0 and s_ready=1 next cycle, then the new frame is accepted and its results are correct.
- Mid-frame reset: pulse reset when coef_idx=100.
  - Required: all outputs return to reset values, and no m_valid appears for the aborted frame.
  - A following impulse frame must produce exactly the values from the single-impulse scenario, with no residue from the aborted frame.
